// File: rtl/fxp_div_pkg.sv
// Shared definitions for the sequential fixed-point restoring divider.
package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N = 4;
  localparam int DEF_F = 4;

  // Ceiling log2, used to size the iteration counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fxp_restoring_div_seq_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface fxp_restoring_div_seq_if
  import fxp_div_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int F = DEF_F
);

  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [N+F-1:0] result;
  logic [N-1:0]   remainder;
  logic           dbz;

  modport master (
    output start, a, b,
    input  busy, done, result, remainder, dbz
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, remainder, dbz
  );

endinterface

// File: rtl/fxp_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract b.
module fxp_div_step
  import fxp_div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N:0]   r,
  input  logic         d_bit,
  input  logic [N-1:0] b,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  // Kept one bit wider than the remainder so the shift can never drop a bit.
  logic [N+1:0] r_shift;

  always_comb begin
    r_shift = {r, d_bit};
    q_bit   = (r_shift >= {2'b00, b});
    r_next  = q_bit ? (r_shift[N:0] - {1'b0, b}) : r_shift[N:0];
  end

endmodule

// File: rtl/fxp_restoring_div_seq.sv
// Sequential unsigned QN.F restoring divider, one quotient bit per clock.
module fxp_restoring_div_seq
  import fxp_div_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int F = DEF_F
) (
  input  logic                    clk,
  input  logic                    rst,
  fxp_restoring_div_seq_if.slave  bus
);

  localparam int WD = N + F;
  localparam int CW = clog2(N + F + 1);
  localparam logic [CW-1:0] LAST = CW'(N + F - 1);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [WD-1:0]  d_sr;
  logic [WD-1:0]  q_sr;
  logic [N:0]     r_reg;
  logic [N-1:0]   b_reg;
  logic [WD-1:0]  result_q;
  logic [N-1:0]   remainder_q;
  logic           dbz_q;

  logic           accept;
  logic           last;
  logic           busy_c;
  logic           done_c;
  logic [N:0]     r_next;
  logic           q_bit;
  logic [WD-1:0]  q_next;

  fxp_div_step #(.N(N)) u_step (
    .r      (r_reg),
    .d_bit  (d_sr[WD-1]),
    .b      (b_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign last   = (cnt == LAST);
  assign q_next = (q_sr << 1) | WD'(q_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Start is honoured in IDLE and DONE only; a zero divisor skips CALC.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE, DONE: begin
        done_c = (state == DONE);
        if (bus.start) begin
          accept     = 1'b1;
          state_next = (bus.b == '0) ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        busy_c = 1'b1;
        if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result holding registers change only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      d_sr        <= '0;
      q_sr        <= '0;
      r_reg       <= '0;
      b_reg       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      d_sr  <= WD'(bus.a) << F;
      q_sr  <= '0;
      r_reg <= '0;
      b_reg <= bus.b;
      if (bus.b == '0) begin
        result_q    <= '1;
        remainder_q <= '0;
        dbz_q       <= 1'b1;
      end
    end else if (state == CALC) begin
      cnt   <= cnt + CW'(1);
      d_sr  <= d_sr << 1;
      q_sr  <= q_next;
      r_reg <= r_next;
      if (last) begin
        result_q    <= q_next;
        remainder_q <= r_next[N-1:0];
        dbz_q       <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.result    = result_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;

endmodule
